layer_mux_sync: RTL
===================

# layer_mux_sync

Registered, parametrised N-to-1 pixel-layer multiplexer for the VGA output path. It selects one of N W-bit pixel sources (background, snake, food, score overlay, ...). Selection changes are buffered and applied only on a frame boundary, so a switch never tears a frame. An optional priority-overlay mode drives out the lowest-index valid layer.

## Interface
- N, 4: number of input channels, 2..16.
- W, 12: pixel width in bits (RGB444 default).
- FILL, 12'h000: value driven when no eligible channel is valid; width W.
- clk  input  1  system/pixel clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid (pixel opaque).
- mode  input  1  0 = select mode, 1 = priority mode (only with LAYER_MUX_PRIORITY_EN).
- sel_req  input  clog2(N)  requested channel.
- sel_load  input  1  one-cycle strobe that captures sel_req into the pending register.
- frame_sync  input  1  one-cycle strobe marking the first pixel of a frame.
- out_data  output  W  registered selected pixel.
- out_valid  output  1  registered valid of the selected pixel.
- active_sel  output  clog2(N)  channel currently in effect.
- pending  output  1  a loaded selection is waiting for frame_sync.
- sel_err  output  1  one-cycle pulse on a rejected load.

## Operation
- Reset values: out_data=0, out_valid=0, active_sel=0, pending=0, sel_err=0, pending_sel=0.
- Load: on sel_load with sel_req<N, pending_sel<=sel_req and pending<=1. A later load before frame_sync overwrites the earlier one; the last load wins.
- Rejected load: sel_load with sel_req>=N is rejected. pending_sel and pending are unchanged, and sel_err pulses high for one cycle.
- Apply: in a cycle with frame_sync=1 and pending=1, the effective selection is pending_sel. At that edge active_sel<=pending_sel and pending<=0.
- Simultaneous load and sync: when sel_load (valid) and frame_sync are both high in the same cycle, the load bypasses the pending register. The effective selection is sel_req, active_sel<=sel_req, and pending ends at 0.
- frame_sync with pending=0: no state change.
- Select mode: out_data<=in_valid[s] ? in_data[s] : FILL and out_valid<=in_valid[s], where s is the effective selection.
- Priority mode: the lowest index i with in_valid[i]=1 wins, giving out_data<=in_data[i] and out_valid<=1. If no channel is valid, out_data<=FILL and out_valid<=0. active_sel/pending bookkeeping continues but does not affect the output.
- Asynchronous reset mid-frame drops any pending selection; after reset, channel 0 is active.

## Timing
- Latency: 1 cycle. Inputs sampled at edge k appear on out_data/out_valid after edge k.
- Selection takes effect on the pixel presented in the same cycle as frame_sync; there is no one-pixel lag at the frame boundary.
- active_sel and pending update at the edge that ends the frame_sync or sel_load cycle.
- sel_err is high for exactly the cycle after the rejected load.
- No combinational path from any input to any output.

## Configuration
- LAYER_MUX_PRIORITY_EN defined: priority mode is compiled in, and the mode input selects behaviour as described above.
- Undefined: the mode port remains but is ignored (treated as 0), and no priority encoder is synthesised. Behaviour is identical to mode=0.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release with in_data ch0=12'hF00, valid=1 -> out_data=12'hF00 one cycle later.
- Deferred switch (N=4): sel_load with sel_req=2 at cycle 5 -> pending=1 and output still shows ch0. frame_sync at cycle 20 with ch2=12'h0F0 -> out_data=12'h0F0 after that edge, active_sel=2, pending=0.
- Last load wins, and bypass: loads of 1 then 3 before sync -> ch3 applied at sync. A load of 1 coincident with frame_sync -> ch1 is effective in that same cycle and pending stays 0.
- Rejected load (N=3): sel_req=3 -> sel_err pulses once, while pending and active_sel stay unchanged.
- Invalid selected channel: in_valid[active]=0 -> out_data=FILL and out_valid=0.
- Priority mode (macro defined, mode=1): valid=4'b1010, ch1=12'h00F -> out_data=12'h00F. With valid=0 -> out_data=FILL and out_valid=0. With the macro undefined, the same stimulus -> select-mode result.

Source files
------------

// File: rtl/layer_mux_sync.sv
// Registered N-to-1 pixel-layer multiplexer with frame-synchronous selection switching.
// Optional priority-overlay mode is compiled in when LAYER_MUX_PRIORITY_EN is defined.
module layer_mux_sync #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 12,
  parameter logic [W-1:0] FILL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*W-1:0]         in_data,
  input  logic [N-1:0]           in_valid,
  input  logic                   mode,
  input  logic [$clog2(N)-1:0]   sel_req,
  input  logic                   sel_load,
  input  logic                   frame_sync,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  output logic [$clog2(N)-1:0]   active_sel,
  output logic                   pending,
  output logic                   sel_err
);

  localparam int unsigned SW = $clog2(N);
  localparam logic [SW:0] N_LIM = N[SW:0];

  logic [W-1:0]  ch [N];
  logic          req_ok, load_ok;
  logic [SW-1:0] eff_sel;
  logic [W-1:0]  sel_data;
  logic          sel_vld;

  logic [W-1:0]  out_data_d,    out_data_q;
  logic          out_valid_d,   out_valid_q;
  logic [SW-1:0] active_sel_d,  active_sel_q;
  logic [SW-1:0] pending_sel_d, pending_sel_q;
  logic          pending_d,     pending_q;
  logic          sel_err_d,     sel_err_q;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      ch[i] = in_data[i*W +: W];
    end
  end

  // A valid load coincident with frame_sync bypasses the pending register,
  // so the new selection drives the very pixel of the frame boundary.
  always_comb begin
    req_ok        = ({1'b0, sel_req} < N_LIM);
    load_ok       = sel_load && req_ok;
    sel_err_d     = sel_load && !req_ok;
    pending_sel_d = load_ok ? sel_req : pending_sel_q;
    eff_sel       = active_sel_q;
    pending_d     = pending_q;
    if (frame_sync) begin
      pending_d = 1'b0;
      if (load_ok) begin
        eff_sel = sel_req;
      end else if (pending_q) begin
        eff_sel = pending_sel_q;
      end
    end else if (load_ok) begin
      pending_d = 1'b1;
    end
    active_sel_d = eff_sel;
  end

  always_comb begin
    sel_vld  = in_valid[eff_sel];
    sel_data = sel_vld ? ch[eff_sel] : FILL;
  end

`ifdef LAYER_MUX_PRIORITY_EN
  logic          pri_found;
  logic [W-1:0]  pri_data;

  always_comb begin
    pri_found = 1'b0;
    pri_data  = FILL;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_valid[i] && !pri_found) begin
        pri_found = 1'b1;
        pri_data  = ch[i];
      end
    end
    out_data_d  = mode ? pri_data  : sel_data;
    out_valid_d = mode ? pri_found : sel_vld;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    out_data_d  = sel_data;
    out_valid_d = sel_vld;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      active_sel_q  <= '0;
      pending_sel_q <= '0;
      pending_q     <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      active_sel_q  <= active_sel_d;
      pending_sel_q <= pending_sel_d;
      pending_q     <= pending_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign active_sel = active_sel_q;
  assign pending    = pending_q;
  assign sel_err    = sel_err_q;

endmodule
